// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory: one bank fills row-by-row while the other
// drains column-by-column in the packing idct_col expects.
module idct_transpose_buffer #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_col,
    output logic                out_last
);

    localparam int WORD_W = 8 * DATA_W;

    logic [WORD_W-1:0] mem [2][8];

    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_row;
    logic [2:0] rd_col;
    logic [1:0] full;
    logic [1:0] full_next;
    logic       wr_fire;
    logic       rd_fire;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rd_col == 3'd7);

    // Storage carries no reset; the full bits alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_row] <= in_row;
        end
    end

    always_comb begin
        full_next = full;
        if (wr_fire && (wr_row == 3'd7)) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_col == 3'd7)) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_col  <= 3'd0;
            full    <= 2'b00;
        end else begin
            full <= full_next;
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

    // Element i of the column is row i's entry at the current column index.
    always_comb begin
        out_col = '0;
        if (out_valid) begin
            for (int i = 0; i < 8; i++) begin
                out_col[i*DATA_W +: DATA_W] = mem[rd_bank][i][int'(rd_col)*DATA_W +: DATA_W];
            end
        end
    end

endmodule
